// File: rtl/hline_mem_arbiter.sv
// rtl/hline_mem_arbiter.sv - round-robin arbiter sharing the hline bus-master port among three requesters
module hline_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BE_W        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [2:0]          rq_req,
  input  logic [2:0]          rq_wr,
  input  logic [3*ADDR_W-1:0] rq_addr,
  input  logic [3*BE_W-1:0]   rq_be,
  input  logic [3*DATA_W-1:0] rq_wdata,
  output logic [2:0]          rq_gnt,
  output logic [2:0]          rq_done,
  output logic                rq_err,
  output logic [DATA_W-1:0]   rq_rdata,
  output logic                mst_rd_req,
  output logic                mst_wr_req,
  output logic [ADDR_W-1:0]   mst_addr,
  output logic [BE_W-1:0]     mst_be,
  output logic [DATA_W-1:0]   mst_wdata,
  input  logic                mst_cmdack,
  input  logic                mst_cmplt,
  input  logic                mst_error,
  input  logic [DATA_W-1:0]   mst_rdata,
  output logic                busy,
  output logic                timeout_flag,
  input  logic                clr_status
);

  // Watchdog counts 0 .. TIMEOUT_CYC-1, so clog2 bits are enough
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_last;
  logic [1:0]          r_idx;
  logic [2:0]          r_gnt;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_wdog;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_tflag;

  logic [1:0]          w_c0;
  logic [1:0]          w_c1;
  logic [1:0]          w_c2;
  logic [1:0]          w_win_idx;
  logic                w_win_vld;
  logic                w_active;
  logic                w_cmplt_take;
  logic                w_wdog_hit;
  logic                w_timeout;

  function automatic logic [1:0] f_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Search order starts just after the last granted requester and wraps 2 -> 0
  assign w_c0 = f_next(r_last);
  assign w_c1 = f_next(w_c0);
  assign w_c2 = f_next(w_c1);

  // Pick the first requesting index in rotated priority order
  always_comb begin
    w_win_vld = 1'b1;
    w_win_idx = w_c0;
    if (rq_req[w_c0]) begin
      w_win_idx = w_c0;
    end else if (rq_req[w_c1]) begin
      w_win_idx = w_c1;
    end else if (rq_req[w_c2]) begin
      w_win_idx = w_c2;
    end else begin
      w_win_vld = 1'b0;
    end
  end

  // Completion is honoured only while a transaction is on the bus; it beats a same-cycle timeout
  assign w_active     = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_cmplt_take = w_active && mst_cmplt;
  assign w_wdog_hit   = (r_wdog == CNT_W'(TIMEOUT_CYC - 1));
  assign w_timeout    = w_active && !mst_cmplt && w_wdog_hit;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the single-outstanding transaction sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_cmplt_take || w_timeout) begin
          w_state_nxt = S_DONE;
        end else if (mst_cmdack) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_cmplt_take || w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant, command latch, watchdog, and completion capture
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_gnt   <= 3'b000;
      r_idx   <= 2'd0;
      r_last  <= 2'd2;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_wdog  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_gnt            <= 3'b000;
            r_gnt[w_win_idx] <= 1'b1;
            r_idx            <= w_win_idx;
            r_wr             <= rq_wr[w_win_idx];
            r_addr           <= rq_addr[int'(w_win_idx) * ADDR_W +: ADDR_W];
            r_be             <= rq_be[int'(w_win_idx) * BE_W +: BE_W];
            r_wdata          <= rq_wdata[int'(w_win_idx) * DATA_W +: DATA_W];
            r_wdog           <= '0;
            r_err            <= 1'b0;
          end
        end
        S_ISSUE, S_WAIT: begin
          r_wdog <= r_wdog + CNT_W'(1);
          if (w_cmplt_take) begin
            r_err <= mst_error;
            if (!r_wr) begin
              r_rdata <= mst_rdata;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        S_DONE: begin
          r_last <= r_idx;
          r_gnt  <= 3'b000;
        end
        default: begin
          r_gnt <= 3'b000;
        end
      endcase
    end
  end

  // Sticky timeout status; a timeout in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_tflag <= 1'b0;
    end else if (w_timeout) begin
      r_tflag <= 1'b1;
    end else if (clr_status) begin
      r_tflag <= 1'b0;
    end
  end

  // Command strobes exist only in ISSUE, so dropping out of ISSUE removes them
  assign mst_rd_req   = (r_state == S_ISSUE) && !r_wr;
  assign mst_wr_req   = (r_state == S_ISSUE) &&  r_wr;
  assign mst_addr     = r_addr;
  assign mst_be       = r_be;
  assign mst_wdata    = r_wdata;

  assign rq_gnt       = r_gnt;
  assign rq_done      = (r_state == S_DONE) ? r_gnt : 3'b000;
  assign rq_err       = (r_state == S_DONE) && r_err;
  assign rq_rdata     = r_rdata;

  assign busy         = (r_state != S_IDLE);
  assign timeout_flag = r_tflag;

endmodule

// File: tb/tb_hline_mem_arbiter.sv
// tb/tb_hline_mem_arbiter.sv - self-checking bench for hline_mem_arbiter
module tb_hline_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic [2:0]      rq_req = '0;
  logic [2:0]      rq_wr = '0;
  logic [3*AW-1:0] rq_addr = '0;
  logic [3*BW-1:0] rq_be = '0;
  logic [3*DW-1:0] rq_wdata = '0;
  logic [2:0]      rq_gnt;
  logic [2:0]      rq_done;
  logic            rq_err;
  logic [DW-1:0]   rq_rdata;
  logic            mst_rd_req;
  logic            mst_wr_req;
  logic [AW-1:0]   mst_addr;
  logic [BW-1:0]   mst_be;
  logic [DW-1:0]   mst_wdata;
  logic            mst_cmdack = 1'b0;
  logic            mst_cmplt = 1'b0;
  logic            mst_error = 1'b0;
  logic [DW-1:0]   mst_rdata = '0;
  logic            busy;
  logic            timeout_flag;
  logic            clr_status = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: last granted index and the held read-data value
  int          m_last = 2;
  logic [31:0] m_rdata = '0;

  // Per-requester stimulus copies used for expectations
  logic        s_wr   [3];
  logic [31:0] s_addr [3];
  logic [3:0]  s_be   [3];
  logic [31:0] s_wd   [3];

  // Observations returned by the bus responder
  bit          obs_seen;
  int          obs_tcmd;
  logic [2:0]  obs_gnt;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic        obs_rd;
  logic        obs_wr;
  int          obs_reqcyc;
  logic [2:0]  obs_done;
  logic        obs_err;
  logic [31:0] obs_rdata;
  int          obs_cdone;
  int          obs_dlen;
  bit          obs_bad;
  logic        obs_tflag;
  logic        obs_busy_after;

  hline_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .nreset(nreset),
    .rq_req(rq_req), .rq_wr(rq_wr), .rq_addr(rq_addr), .rq_be(rq_be), .rq_wdata(rq_wdata),
    .rq_gnt(rq_gnt), .rq_done(rq_done), .rq_err(rq_err), .rq_rdata(rq_rdata),
    .mst_rd_req(mst_rd_req), .mst_wr_req(mst_wr_req), .mst_addr(mst_addr), .mst_be(mst_be),
    .mst_wdata(mst_wdata), .mst_cmdack(mst_cmdack), .mst_cmplt(mst_cmplt), .mst_error(mst_error),
    .mst_rdata(mst_rdata), .busy(busy), .timeout_flag(timeout_flag), .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  // Rotating-priority winner: first requester after the last grant, wrapping around
  function automatic int model_winner(input logic [2:0] mask);
    for (int k = 1; k <= 3; k++) begin
      if (mask[(m_last + k) % 3]) return (m_last + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] onehot(input int w);
    logic [2:0] v;
    v = 3'b000;
    if (w >= 0 && w <= 2) v[w] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
    s_wr[i] = wr; s_addr[i] = a; s_be[i] = b; s_wd[i] = d;
    rq_wr[i] = wr;
    rq_addr[i*AW +: AW] = a;
    rq_be[i*BW +: BW] = b;
    rq_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    rq_req = '0; mst_cmdack = 0; mst_cmplt = 0; mst_error = 0; clr_status = 0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    m_last = 2;
    m_rdata = '0;
  endtask

  // Bus responder: waits for a grant, acks at cycle ack_d, completes at cycle cpl_d
  // (negative = never), optionally drops all requests at cycle drop_c
  task automatic serve(input int ack_d, input int cpl_d, input logic err,
                       input logic [31:0] rd, input int drop_c);
    obs_seen = 0; obs_tcmd = 0; obs_reqcyc = 0; obs_done = '0; obs_err = 0;
    obs_rdata = '0; obs_cdone = -1; obs_dlen = 0; obs_bad = 0; obs_tflag = 0;
    obs_gnt = '0; obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_rd = 0; obs_wr = 0;
    while (rq_gnt == 3'b000 && obs_tcmd < 20) begin
      @(posedge clk); #1;
      obs_tcmd++;
    end
    if (rq_gnt == 3'b000) return;
    obs_seen = 1;
    obs_gnt = rq_gnt; obs_addr = mst_addr; obs_be = mst_be; obs_wdata = mst_wdata;
    obs_rd = mst_rd_req; obs_wr = mst_wr_req;
    for (int c = 0; c < 64; c++) begin
      if (mst_rd_req || mst_wr_req) obs_reqcyc++;
      if ($countones(rq_gnt) > 1 || (mst_rd_req && mst_wr_req)) obs_bad = 1;
      if (c == drop_c) rq_req = 3'b000;
      mst_cmdack = (c == ack_d);
      mst_cmplt  = (c == cpl_d);
      mst_error  = err && (c == cpl_d);
      mst_rdata  = (c == cpl_d) ? rd : $urandom;
      @(posedge clk); #1;
      mst_cmdack = 0; mst_cmplt = 0; mst_error = 0;
      if (rq_done != 3'b000) begin
        obs_done = rq_done; obs_err = rq_err; obs_rdata = rq_rdata;
        obs_cdone = c + 1; obs_tflag = timeout_flag;
        break;
      end
    end
    while (rq_done != 3'b000 && obs_dlen < 4) begin
      obs_dlen++;
      if ($countones(rq_gnt) > 1) obs_bad = 1;
      @(posedge clk); #1;
    end
    obs_busy_after = busy;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    rq_req = 3'b111;
    mst_cmplt = 1'b1; mst_cmdack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({rq_gnt, rq_done, rq_err, mst_rd_req, mst_wr_req, busy, timeout_flag} !== 11'd0) begin
      n_errors++; $display("FAIL reset_ctrl got %b want 0", {rq_gnt, rq_done, rq_err, mst_rd_req, mst_wr_req, busy, timeout_flag}); end
    n_checks++; if ({mst_addr, mst_be, mst_wdata, rq_rdata} !== '0) begin
      n_errors++; $display("FAIL reset_data got %h/%h/%h/%h want 0", mst_addr, mst_be, mst_wdata, rq_rdata); end
    rq_req = 3'b000; mst_cmplt = 0; mst_cmdack = 0;
    nreset = 1'b1;
    m_last = 2; m_rdata = '0;
    @(posedge clk); #1;
    n_checks++; if ({busy, rq_gnt} !== 4'd0) begin
      n_errors++; $display("FAIL reset_idle got busy=%b gnt=%b want 0", busy, rq_gnt); end
  endtask

  task automatic test_read();
    set_req(0, 1'b0, 32'h1000_0000, 4'hF, $urandom);
    rq_req = 3'b001;
    serve(2, 5, 1'b0, 32'hDEAD_BEEF, -1);
    rq_req = 3'b000;
    n_checks++; if (obs_tcmd !== 1) begin n_errors++; $display("FAIL rd_latency got %0d want 1", obs_tcmd); end
    n_checks++; if ({obs_gnt, obs_rd, obs_wr} !== {3'b001, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL rd_cmd got gnt=%b rd=%b wr=%b want 001/1/0", obs_gnt, obs_rd, obs_wr); end
    n_checks++; if (obs_addr !== 32'h1000_0000) begin n_errors++; $display("FAIL rd_addr got %h want 10000000", obs_addr); end
    n_checks++; if (obs_reqcyc !== 3) begin n_errors++; $display("FAIL rd_reqcyc got %0d want 3", obs_reqcyc); end
    n_checks++; if (obs_cdone !== 6) begin n_errors++; $display("FAIL rd_done_cycle got %0d want 6", obs_cdone); end
    n_checks++; if ({obs_done, obs_err} !== {3'b001, 1'b0}) begin
      n_errors++; $display("FAIL rd_done got %b err=%b want 001/0", obs_done, obs_err); end
    n_checks++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL rd_rdata got %h want deadbeef", obs_rdata); end
    n_checks++; if ({obs_dlen, obs_busy_after} !== {32'd1, 1'b0}) begin
      n_errors++; $display("FAIL rd_pulse got len=%0d busy=%b want 1/0", obs_dlen, obs_busy_after); end
    m_last = 0; m_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_round_robin();
    int w;
    logic [31:0] rd;
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
    rq_req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      rd = $urandom;
      serve(0, 0, 1'b0, rd, -1);
      w = model_winner(3'b111);
      n_checks++; if ({obs_gnt, obs_done} !== {onehot(w), onehot(w)}) begin
        n_errors++; $display("FAIL rr_order n=%0d got gnt=%b done=%b want %b", n, obs_gnt, obs_done, onehot(w)); end
      n_checks++; if ({obs_bad, obs_dlen} !== {1'b0, 32'd1}) begin
        n_errors++; $display("FAIL rr_onehot n=%0d got bad=%b len=%0d want 0/1", n, obs_bad, obs_dlen); end
      n_checks++; if (obs_addr !== s_addr[w]) begin
        n_errors++; $display("FAIL rr_addr n=%0d got %h want %h", n, obs_addr, s_addr[w]); end
      if (!s_wr[w]) m_rdata = rd;
      m_last = w;
    end
    rq_req = 3'b000;
  endtask

  task automatic test_error();
    logic [31:0] wd;
    wd = $urandom;
    set_req(2, 1'b1, 32'h0000_1234, 4'b0011, wd);
    rq_req = 3'b100;
    serve(1, 3, 1'b1, $urandom, -1);
    rq_req = 3'b000;
    n_checks++; if ({obs_done, obs_err, obs_tflag} !== {3'b100, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL err_done got %b err=%b tflag=%b want 100/1/0", obs_done, obs_err, obs_tflag); end
    n_checks++; if ({obs_wr, obs_rd, obs_addr, obs_be, obs_wdata} !== {1'b1, 1'b0, 32'h0000_1234, 4'b0011, wd}) begin
      n_errors++; $display("FAIL err_cmd got wr=%b addr=%h be=%b wd=%h want 1/00001234/0011/%h", obs_wr, obs_addr, obs_be, obs_wdata, wd); end
    n_checks++; if (obs_rdata !== m_rdata) begin n_errors++; $display("FAIL err_rdata_held got %h want %h", obs_rdata, m_rdata); end
    m_last = 2;
    mst_cmplt = 1; mst_cmdack = 1; mst_error = 1;
    @(posedge clk); #1;
    mst_cmplt = 0; mst_cmdack = 0; mst_error = 0;
    n_checks++; if ({rq_done, rq_err, busy, timeout_flag} !== 6'd0) begin
      n_errors++; $display("FAIL idle_ignore got done=%b err=%b busy=%b tflag=%b want 0", rq_done, rq_err, busy, timeout_flag); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    set_req(0, 1'b0, $urandom, 4'hF, $urandom);
    rq_req = 3'b001;
    serve(1, -1, 1'b0, '0, -1);
    rq_req = 3'b000;
    n_checks++; if (obs_cdone !== TO) begin n_errors++; $display("FAIL to_cycle got %0d want %0d", obs_cdone, TO); end
    n_checks++; if ({obs_done, obs_err, obs_tflag} !== {3'b001, 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL to_done got %b err=%b tflag=%b want 001/1/1", obs_done, obs_err, obs_tflag); end
    n_checks++; if ({obs_reqcyc, obs_rdata} !== {32'd2, m_rdata}) begin
      n_errors++; $display("FAIL to_req got reqcyc=%0d rdata=%h want 2/%h", obs_reqcyc, obs_rdata, m_rdata); end
    m_last = 0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (timeout_flag !== 1'b1) begin n_errors++; $display("FAIL to_sticky got %b want 1", timeout_flag); end
    clr_status = 1; @(posedge clk); #1; clr_status = 0;
    n_checks++; if (timeout_flag !== 1'b0) begin n_errors++; $display("FAIL to_clear got %b want 0", timeout_flag); end
    clr_status = 1;
    set_req(1, 1'b1, $urandom, 4'($urandom), $urandom);
    rq_req = 3'b010;
    serve(-1, -1, 1'b0, '0, -1);
    rq_req = 3'b000;
    n_checks++; if ({obs_reqcyc, obs_cdone} !== {TO, TO}) begin
      n_errors++; $display("FAIL to_noack got reqcyc=%0d done_cyc=%0d want %0d/%0d", obs_reqcyc, obs_cdone, TO, TO); end
    n_checks++; if ({obs_done, obs_err, obs_tflag} !== {3'b010, 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL to_setwins got %b err=%b tflag=%b want 010/1/1", obs_done, obs_err, obs_tflag); end
    n_checks++; if (timeout_flag !== 1'b0) begin n_errors++; $display("FAIL to_clr_after got %b want 0", timeout_flag); end
    clr_status = 0;
    m_last = 1;
    rd = $urandom;
    set_req(2, 1'b0, $urandom, 4'hF, $urandom);
    rq_req = 3'b100;
    serve(0, 2, 1'b0, rd, -1);
    rq_req = 3'b000;
    n_checks++; if ({obs_done, obs_err, obs_rdata, obs_cdone} !== {3'b100, 1'b0, rd, 32'd3}) begin
      n_errors++; $display("FAIL to_recover got %b err=%b rdata=%h cyc=%0d want 100/0/%h/3", obs_done, obs_err, obs_rdata, obs_cdone, rd); end
    m_last = 2; m_rdata = rd;
  endtask

  task automatic test_same_cycle_drop();
    logic [31:0] rd;
    set_req(1, 1'b1, $urandom, 4'($urandom), $urandom);
    rq_req = 3'b010;
    serve(2, 2, 1'b0, $urandom, -1);
    rq_req = 3'b000;
    n_checks++; if ({obs_done, obs_cdone, obs_reqcyc} !== {3'b010, 32'd3, 32'd3}) begin
      n_errors++; $display("FAIL same_cyc got done=%b cyc=%0d reqcyc=%0d want 010/3/3", obs_done, obs_cdone, obs_reqcyc); end
    m_last = 1;
    rd = $urandom;
    set_req(1, 1'b0, $urandom, 4'hF, $urandom);
    rq_req = 3'b010;
    serve(0, 4, 1'b0, rd, 2);
    n_checks++; if ({obs_done, obs_err, obs_rdata, obs_cdone} !== {3'b010, 1'b0, rd, 32'd5}) begin
      n_errors++; $display("FAIL drop_req got done=%b err=%b rdata=%h cyc=%0d want 010/0/%h/5", obs_done, obs_err, obs_rdata, obs_cdone, rd); end
    m_last = 1; m_rdata = rd;
  endtask

  task automatic test_async_reset();
    int k;
    int w;
    logic [31:0] rd;
    for (int i = 0; i < 3; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
    s_wr[0] = 1'b0; rq_wr[0] = 1'b0;
    rq_req = 3'b111;
    k = 0;
    while (rq_gnt == 3'b000 && k < 20) begin @(posedge clk); #1; k++; end
    w = model_winner(3'b111);
    n_checks++; if (rq_gnt !== onehot(w)) begin n_errors++; $display("FAIL ar_gnt got %b want %b", rq_gnt, onehot(w)); end
    mst_cmdack = 1; @(posedge clk); #1; mst_cmdack = 0;
    @(posedge clk); #1;
    n_checks++; if ({busy, mst_rd_req, mst_wr_req} !== 3'b100) begin
      n_errors++; $display("FAIL ar_wait got busy=%b rd=%b wr=%b want 1/0/0", busy, mst_rd_req, mst_wr_req); end
    #3 nreset = 1'b0;
    #1;
    n_checks++; if ({rq_gnt, rq_done, mst_rd_req, mst_wr_req, busy, mst_addr, rq_rdata} !== '0) begin
      n_errors++; $display("FAIL ar_async got gnt=%b done=%b busy=%b addr=%h want 0", rq_gnt, rq_done, busy, mst_addr); end
    mst_cmplt = 1;
    @(posedge clk); #1;
    mst_cmplt = 0;
    n_checks++; if ({rq_done, busy} !== 4'd0) begin n_errors++; $display("FAIL ar_abandon got done=%b busy=%b want 0", rq_done, busy); end
    nreset = 1'b1;
    m_last = 2; m_rdata = '0;
    rd = $urandom;
    serve(1, 2, 1'b0, rd, -1);
    rq_req = 3'b000;
    n_checks++; if ({obs_gnt, obs_done, obs_rdata} !== {3'b001, 3'b001, rd}) begin
      n_errors++; $display("FAIL ar_first got gnt=%b done=%b rdata=%h want 001/001/%h", obs_gnt, obs_done, obs_rdata, rd); end
    m_last = 0; m_rdata = rd;
  endtask

  task automatic test_random();
    logic [2:0]  mask;
    logic [31:0] rd;
    logic        err;
    logic [31:0] exp_rd;
    int ack_d, cpl_d, drop_c, w;
    for (int n = 0; n < 40; n++) begin
      mask = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
      ack_d = $urandom_range(0, 3);
      cpl_d = ack_d + $urandom_range(0, 3);
      drop_c = ($urandom_range(0, 3) == 0) ? ack_d : -1;
      err = 1'($urandom_range(0, 1));
      rd = $urandom;
      rq_req = mask;
      serve(ack_d, cpl_d, err, rd, drop_c);
      w = model_winner(mask);
      exp_rd = s_wr[w] ? m_rdata : rd;
      n_checks++; if ({obs_seen, obs_gnt, obs_done, obs_err} !== {1'b1, onehot(w), onehot(w), err}) begin
        n_errors++; $display("FAIL rnd_grant n=%0d got gnt=%b done=%b err=%b want %b/%b", n, obs_gnt, obs_done, obs_err, onehot(w), err); end
      n_checks++; if ({obs_addr, obs_be, obs_wdata, obs_wr, obs_rd} !== {s_addr[w], s_be[w], s_wd[w], s_wr[w], ~s_wr[w]}) begin
        n_errors++; $display("FAIL rnd_cmd n=%0d got %h/%b/%h wr=%b want %h/%b/%h wr=%b", n, obs_addr, obs_be, obs_wdata, obs_wr, s_addr[w], s_be[w], s_wd[w], s_wr[w]); end
      n_checks++; if (obs_rdata !== exp_rd) begin
        n_errors++; $display("FAIL rnd_rdata n=%0d got %h want %h", n, obs_rdata, exp_rd); end
      n_checks++; if ({obs_cdone, obs_reqcyc, obs_dlen, obs_bad} !== {cpl_d + 1, ack_d + 1, 32'd1, 1'b0}) begin
        n_errors++; $display("FAIL rnd_timing n=%0d got cyc=%0d reqcyc=%0d len=%0d bad=%b want %0d/%0d/1/0", n, obs_cdone, obs_reqcyc, obs_dlen, obs_bad, cpl_d + 1, ack_d + 1); end
      m_last = w;
      m_rdata = exp_rd;
    end
    rq_req = 3'b000;
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_error();
    test_timeout();
    test_same_cycle_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

endmodule
